// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank with per-register RW / RO / W1C / PULSE behaviour.
// Independent write and read FSMs; one-cycle access strobes per register.

module axi4lite_regbank_reg #(
  parameter int              DW   = 32,
  parameter logic [1:0]      KIND = 2'd0,  // 0 RW, 1 RO, 2 W1C, 3 PULSE
  parameter logic [DW-1:0]   RST  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic [DW-1:0]   hw_d,
  input  logic [DW-1:0]   hw_set,
  output logic [DW-1:0]   q
);
  localparam logic [1:0] K_RW = 2'd0, K_RO = 2'd1, K_W1C = 2'd2, K_PULSE = 2'd3;

  logic [DW-1:0] q_r, bmask, wbits;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < DW/8; b++) bmask[b*8 +: 8] = {8{wstrb[b]}};
  end
  assign wbits = wdata & bmask;

  // hw_set is OR'd after the clear so a simultaneous set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_r <= (KIND == K_PULSE) ? '0 : RST;
    else begin
      case (KIND)
        K_RW:    if (wr_en) q_r <= (q_r & ~bmask) | wbits;
        K_W1C:   q_r <= (q_r & ~(wr_en ? wbits : '0)) | hw_set;
        K_PULSE: q_r <= wr_en ? wbits : '0;
        default: q_r <= q_r;
      endcase
    end
  end

  assign q = (KIND == K_RO) ? hw_d : q_r;
endmodule

module axi4lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 11,
  parameter int REG_N              = 16,
  parameter logic [REG_N-1:0] RO_MASK    = '0,
  parameter logic [REG_N-1:0] W1C_MASK   = '0,
  parameter logic [REG_N-1:0] PULSE_MASK = '0,
  parameter logic [REG_N*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [REG_N*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  input  logic [REG_N*C_S_AXI_DATA_WIDTH-1:0] reg_hw_d,
  input  logic [REG_N*C_S_AXI_DATA_WIDTH-1:0] reg_hw_set,
  output logic [REG_N-1:0]                  reg_wr_pulse,
  output logic [REG_N-1:0]                  reg_rd_pulse
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int LSB   = $clog2(DW/8);
  localparam int IDX_W = AW - LSB;
  localparam logic [1:0] K_RW = 2'd0, K_RO = 2'd1, K_W1C = 2'd2, K_PULSE = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_DATA} rst_t;

  wst_t wst, wst_nxt;
  rst_t rst, rst_nxt;
  logic w_acc, r_acc, w_ok, r_ok;
  logic [IDX_W-1:0] widx, ridx;
  logic [REG_N-1:0] wr_sel, rd_sel;
  logic [REG_N-1:0][DW-1:0] q_arr;
  logic [DW-1:0] rd_val;
  logic unused_ok;

  assign widx = S_AXI_AWADDR[AW-1:LSB];
  assign ridx = S_AXI_ARADDR[AW-1:LSB];
  assign w_ok = 32'(widx) < REG_N;
  assign r_ok = 32'(ridx) < REG_N;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  // write FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) wst <= W_IDLE;
    else                wst <= wst_nxt;

  always_comb begin
    wst_nxt = wst;
    case (wst)
      W_IDLE:  if (w_acc) wst_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY) wst_nxt = W_IDLE;
      default: wst_nxt = W_IDLE;
    endcase
  end

  // ready gated by reset so nothing is accepted before the first edge after release
  always_comb begin
    w_acc        = 1'b0;
    S_AXI_BVALID = 1'b0;
    case (wst)
      W_IDLE:  w_acc = S_AXI_ARESETN && S_AXI_AWVALID && S_AXI_WVALID;
      W_RESP:  S_AXI_BVALID = 1'b1;
      default: ;
    endcase
  end
  assign S_AXI_AWREADY = w_acc;
  assign S_AXI_WREADY  = w_acc;

  // read FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) rst <= R_IDLE;
    else                rst <= rst_nxt;

  always_comb begin
    rst_nxt = rst;
    case (rst)
      R_IDLE:  if (r_acc) rst_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rst_nxt = R_IDLE;
      default: rst_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    r_acc        = 1'b0;
    S_AXI_RVALID = 1'b0;
    case (rst)
      R_IDLE:  r_acc = S_AXI_ARESETN && S_AXI_ARVALID;
      R_DATA:  S_AXI_RVALID = 1'b1;
      default: ;
    endcase
  end
  assign S_AXI_ARREADY = r_acc;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < REG_N; i++)
      if (32'(ridx) == i) rd_val = q_arr[i];
  end

  // rd_val is sampled before the same-edge register update, so a colliding read sees the old value
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_BRESP  <= 2'b00;
      S_AXI_RRESP  <= 2'b00;
      S_AXI_RDATA  <= '0;
      reg_wr_pulse <= '0;
      reg_rd_pulse <= '0;
    end else begin
      reg_wr_pulse <= wr_sel;
      reg_rd_pulse <= rd_sel;
      if (w_acc) S_AXI_BRESP <= w_ok ? 2'b00 : 2'b10;
      if (r_acc) begin
        S_AXI_RRESP <= r_ok ? 2'b00 : 2'b10;
        S_AXI_RDATA <= r_ok ? rd_val : '0;
      end
    end
  end

  for (genvar i = 0; i < REG_N; i++) begin : g_reg
    localparam logic [1:0] KIND = RO_MASK[i]    ? K_RO    :
                                  W1C_MASK[i]   ? K_W1C   :
                                  PULSE_MASK[i] ? K_PULSE : K_RW;
    assign wr_sel[i] = w_acc && (32'(widx) == i);
    assign rd_sel[i] = r_acc && (32'(ridx) == i);

    axi4lite_regbank_reg #(.DW(DW), .KIND(KIND), .RST(RESET_VAL[i*DW +: DW])) u_reg (
      .clk   (S_AXI_ACLK),
      .rst_n (S_AXI_ARESETN),
      .wr_en (wr_sel[i]),
      .wdata (S_AXI_WDATA),
      .wstrb (S_AXI_WSTRB),
      .hw_d  (reg_hw_d[i*DW +: DW]),
      .hw_set(reg_hw_set[i*DW +: DW]),
      .q     (q_arr[i])
    );
  end

  assign reg_q = q_arr;
endmodule

// File: tb/tb_axi4lite_regbank.sv
// Randomized bench for axi4lite_regbank against an array-based register model.
module tb_axi4lite_regbank;
  localparam int DW = 32, AW = 11, N = 16;
  localparam logic [N-1:0] RO_M  = 16'h0020;
  localparam logic [N-1:0] W1C_M = 16'h0068;
  localparam logic [N-1:0] PUL_M = 16'h00D0;
  localparam logic [N*DW-1:0] RST_V = {32'h0, 32'h0, 32'h0, 32'h0,
                                       32'h0, 32'h0, 32'h0, 32'h12345678,
                                       32'h0000FFFF, 32'h000000F0, 32'h0000AAAA, 32'h0,
                                       32'h0, 32'h0, 32'hDEADBEEF, 32'h0};

  logic clk = 0, rst_n = 0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [DW-1:0] wdata = '0, rdata;
  logic [DW/8-1:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [N*DW-1:0] reg_q, hw_d = '0, hw_set = '0;
  logic [N-1:0] wr_pulse, rd_pulse;

  logic [DW-1:0] mdl [N];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  axi4lite_regbank #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .REG_N(N),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .PULSE_MASK(PUL_M), .RESET_VAL(RST_V)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_hw_d(hw_d), .reg_hw_set(hw_set),
    .reg_wr_pulse(wr_pulse), .reg_rd_pulse(rd_pulse));

  task automatic chk(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // 0 RW, 1 RO, 2 W1C, 3 PULSE; RO beats W1C beats PULSE
  function automatic int kind(input int i);
    if (RO_M[i])  return 1;
    if (W1C_M[i]) return 2;
    if (PUL_M[i]) return 3;
    return 0;
  endfunction

  function automatic logic [DW-1:0] smask(input logic [DW/8-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < DW/8; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [DW-1:0] exp_q(input int i);
    return (kind(i) == 1) ? hw_d[i*DW +: DW] : mdl[i];
  endfunction

  function automatic logic [N*DW-1:0] exp_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_q(i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl[i] = (kind(i) == 3) ? '0 : RST_V[i*DW +: DW];
  endtask

  task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                             input logic [N*DW-1:0] hs);
    logic [DW-1:0] m, clr;
    m = smask(s);
    for (int j = 0; j < N; j++)
      if (kind(j) == 2) begin
        clr = (j == idx) ? (d & m) : '0;
        mdl[j] = (mdl[j] & ~clr) | hs[j*DW +: DW];
      end
    if (idx < N && kind(idx) == 0) mdl[idx] = (mdl[idx] & ~m) | (d & m);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                    input int aw_lead, input int b_hold, input logic [N*DW-1:0] hs);
    int idx;
    bit ok;
    logic [N-1:0] pexp;
    idx = int'(a >> 2);
    pexp = (idx < N) ? (N'(1) << idx) : '0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1;
    for (int k = 0; k < aw_lead; k++) begin
      @(negedge clk); chk("aw_alone_ready", {awready, wready}, 0);
      @(posedge clk); #1;
    end
    wvalid = 1; hw_set = hs;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = awready && wready;
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0; hw_set = '0;
    chk("w_handshake", ok, 1);
    model_write(idx, d, s, hs);
    chk("bvalid_rise", bvalid, 1);
    chk("bresp", bresp, (idx < N) ? 2'b00 : 2'b10);
    chk("wr_pulse", wr_pulse, pexp);
    if (idx < N && kind(idx) == 3) chk("pulse_hi", reg_q[idx*DW +: DW], d & smask(s));
    for (int k = 0; k < b_hold; k++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", bvalid, 1);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("bvalid_drop", bvalid, 0);
    chk("wr_pulse_off", wr_pulse, 0);
    chk("reg_q_after_wr", reg_q, exp_vec());
  endtask

  task automatic rd(input logic [AW-1:0] a, input int r_hold);
    int idx;
    bit ok;
    logic [DW-1:0] ed;
    idx = int'(a >> 2);
    ed = (idx < N) ? exp_q(idx) : '0;
    araddr = a; arvalid = 1;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    chk("r_handshake", ok, 1);
    chk("rvalid_rise", rvalid, 1);
    chk("rd_pulse", rd_pulse, (idx < N) ? (N'(1) << idx) : '0);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, (idx < N) ? 2'b00 : 2'b10);
    for (int k = 0; k < r_hold; k++) begin
      @(posedge clk); #1;
      chk("rdata_hold", {rvalid, rdata}, {1'b1, ed});
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
    chk("rd_pulse_off", rd_pulse, 0);
  endtask

  task automatic rw_same(input int idx, input logic [DW-1:0] d);
    bit ok;
    logic [DW-1:0] old;
    old = exp_q(idx);
    awaddr = AW'(idx << 2); araddr = AW'(idx << 2); wdata = d; wstrb = '1;
    awvalid = 1; wvalid = 1; arvalid = 1;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = awready && wready && arready;
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("rw_handshake", ok, 1);
    model_write(idx, d, '1, '0);
    chk("rw_old_data", rdata, old);
    chk("rw_valids", {bvalid, rvalid}, 2'b11);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    chk("rw_reg_q", reg_q, exp_vec());
  endtask

  task automatic hw_pulse(input int idx, input logic [DW-1:0] bits);
    hw_set[idx*DW +: DW] = bits;
    @(posedge clk); #1;
    hw_set = '0;
    if (kind(idx) == 2) mdl[idx] = mdl[idx] | bits;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N*DW-1:0] hs;
    int idx, r;
    for (int i = 0; i < N; i++) hw_d[i*DW +: DW] = $urandom;
    model_reset();
    #12;
    chk("rst_ready_valid", {awready, wready, bvalid, arready, rvalid}, 0);
    chk("rst_data_resp", {rdata, bresp, rresp}, 0);
    chk("rst_strobes", {wr_pulse, rd_pulse}, 0);
    chk("rst_reg_q", reg_q, exp_vec());
    @(posedge clk); #1 rst_n = 1;

    // RW with partial strobes
    wr(AW'(2 << 2), 32'hA5A5_1234, 4'b0011, 0, 0, '0);
    chk("rw_partial_strobe", reg_q[2*DW +: DW], 32'h0000_1234);

    // out-of-range index
    rd(AW'('h400), 0);
    wr(AW'('h400), 32'hFFFF_FFFF, 4'hF, 0, 0, '0);

    // W1C: set wins over clear on the same bit
    hw_pulse(3, 32'h0F);
    rd(AW'(3 << 2), 0);
    chk("w1c_set", reg_q[3*DW +: DW], 32'h0F);
    hs = '0; hs[3*DW +: DW] = 32'h01;
    wr(AW'(3 << 2), 32'h05, 4'hF, 0, 0, hs);
    chk("w1c_clear_set", reg_q[3*DW +: DW], 32'h0B);

    // PULSE write and read held by RREADY low
    wr(AW'(4 << 2), 32'h1, 4'hF, 0, 0, '0);
    rd(AW'(4 << 2), 5);
    rd(AW'(8 << 2), 5);

    // AWVALID ahead of WVALID, BREADY held low
    wr(AW'(2 << 2), 32'hCAFE_F00D, 4'hF, 3, 3, '0);

    // mask precedence: RO over W1C (reg5), W1C over PULSE (reg6), PULSE (reg7)
    wr(AW'(5 << 2), 32'hFFFF_FFFF, 4'hF, 0, 0, '0);
    rd(AW'(5 << 2), 0);
    wr(AW'(6 << 2), 32'h30, 4'h1, 0, 0, '0);
    rd(AW'(6 << 2), 0);
    wr(AW'(7 << 2), 32'h8000_0001, 4'hF, 0, 0, '0);

    rw_same(2, 32'h1357_9BDF);
    rw_same(8, 32'h0246_8ACE);

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(N, 511) : $urandom_range(0, N-1);
      if ($urandom_range(0, 4) == 0) begin
        hw_d[5*DW +: DW] = $urandom;
        hw_d[0 +: DW] = $urandom;
      end
      if (r < 5) begin
        hs = '0;
        for (int j = 0; j < N; j++)
          if ($urandom_range(0, 3) == 0) hs[j*DW +: DW] = $urandom;
        wr(AW'((idx << 2) | $urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2), $urandom_range(0, 2), hs);
      end else if (r < 9) begin
        rd(AW'((idx << 2) | $urandom_range(0, 3)), $urandom_range(0, 3));
      end else begin
        rw_same($urandom_range(0, N-1), $urandom);
      end
    end

    // reset while a write response is pending
    awaddr = AW'(2 << 2); wdata = 32'h7777_7777; wstrb = '1; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    chk("rst_pre_bvalid", bvalid, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_bvalid_async", bvalid, 0);
    chk("rst_mid_reg_q", reg_q, exp_vec());
    awvalid = 1; wvalid = 1;
    @(negedge clk);
    chk("rst_no_accept", {awready, wready}, 0);
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_bvalid_after_rst", bvalid, 0);
    end
    chk("post_rst_reg_q", reg_q, exp_vec());
    rd(AW'(1 << 2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
